// File: rtl/reset_seq.sv
// Reset sequencer: synchronises PLL lock flags and the board reset button,
// filters lock glitches, then releases the reset domains one at a time with a
// fixed spacing. Any loss of good inputs or a software request pulls every
// domain back into reset and restarts the whole sequence from HOLD.
module reset_seq #(
  parameter int unsigned N_LOCK      = 2,
  parameter int unsigned N_DOM       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILT   = 16,
  parameter int unsigned STEP_DLY    = 64,
  parameter int unsigned LOSS_W      = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [N_LOCK-1:0] LOCKED,
  input  logic              EXT_RSTn,
  input  logic              SW_REQ,
  output logic [N_DOM-1:0]  RST_OUTn,
  output logic              READY,
  output logic [LOSS_W-1:0] LOSS_CNT,
  output logic [1:0]        STATE
);

  localparam int unsigned FW   = $clog2(LOCK_FILT + 1);
  localparam int unsigned SW_W = $clog2(STEP_DLY + 1);
  localparam int unsigned DW   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [FW-1:0]   FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [SW_W-1:0] STEP_LAST = SW_W'(STEP_DLY - 1);
  localparam logic [DW-1:0]   DOM_LAST  = DW'(N_DOM - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][N_LOCK-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0]             r_ext_sync;
  logic                               w_all_ok;

  state_t            r_state,    w_state_nxt;
  logic [FW-1:0]     r_filt_cnt, w_filt_nxt;
  logic [SW_W-1:0]   r_step_cnt, w_step_nxt;
  logic [DW-1:0]     r_dom_idx,  w_dom_nxt;
  logic [N_DOM-1:0]  r_rst_out,  w_rst_nxt;
  logic              r_ready,    w_ready_nxt;
  logic [LOSS_W-1:0] r_loss_cnt, w_loss_nxt;
  logic              w_go_rel;
  logic              w_abort;
  logic              w_loss;

  // Synchroniser chains for the asynchronous lock flags and reset button
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_lock_sync <= '0;
      r_ext_sync  <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], LOCKED};
      r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], EXT_RSTn};
    end
  end

  assign w_all_ok = (&r_lock_sync[SYNC_STAGES-1]) & r_ext_sync[SYNC_STAGES-1];

  // Sequencer state, counters and registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= ST_HOLD;
      r_filt_cnt <= '0;
      r_step_cnt <= '0;
      r_dom_idx  <= '0;
      r_rst_out  <= '0;
      r_ready    <= 1'b0;
      r_loss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_filt_cnt <= w_filt_nxt;
      r_step_cnt <= w_step_nxt;
      r_dom_idx  <= w_dom_nxt;
      r_rst_out  <= w_rst_nxt;
      r_ready    <= w_ready_nxt;
      r_loss_cnt <= w_loss_nxt;
    end
  end

  // Next-state logic; the filter counter holds the number of good cycles
  // already seen, so release fires on the edge that would make it LOCK_FILT.
  // Entering RELEASE and aborting to HOLD are shared actions applied after
  // the case so every state takes the same path.
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = r_filt_cnt;
    w_step_nxt  = r_step_cnt;
    w_dom_nxt   = r_dom_idx;
    w_rst_nxt   = r_rst_out;
    w_ready_nxt = r_ready;
    w_loss_nxt  = r_loss_cnt;
    w_go_rel    = 1'b0;
    w_abort     = 1'b0;
    w_loss      = 1'b0;

    case (r_state)
      ST_HOLD: begin
        if (w_all_ok) begin
          if (LOCK_FILT == 1) begin
            w_go_rel = 1'b1;
          end else begin
            w_state_nxt = ST_FILTER;
            w_filt_nxt  = FW'(1);
          end
        end
      end
      ST_FILTER: begin
        if (!w_all_ok || SW_REQ) begin
          w_abort = 1'b1;
        end else if (r_filt_cnt == FILT_LAST) begin
          w_go_rel = 1'b1;
        end else begin
          w_filt_nxt = r_filt_cnt + FW'(1);
        end
      end
      ST_RELEASE: begin
        if (!w_all_ok) begin
          w_loss = 1'b1;
        end else if (SW_REQ) begin
          w_abort = 1'b1;
        end else if (r_step_cnt == STEP_LAST) begin
          w_step_nxt = '0;
          for (int unsigned i = 0; i < N_DOM; i++) begin
            if (DW'(i) == r_dom_idx) begin
              w_rst_nxt[i] = 1'b1;
            end
          end
          if (r_dom_idx == DOM_LAST) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_dom_nxt = r_dom_idx + DW'(1);
          end
        end else begin
          w_step_nxt = r_step_cnt + SW_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_all_ok) begin
          w_loss = 1'b1;
        end else if (SW_REQ) begin
          w_abort = 1'b1;
        end
      end
      default: begin
        w_abort = 1'b1;
      end
    endcase

    if (w_go_rel) begin
      w_filt_nxt = '0;
      w_step_nxt = '0;
      w_rst_nxt  = N_DOM'(1);
      if (N_DOM == 1) begin
        w_state_nxt = ST_RUN;
        w_ready_nxt = 1'b1;
        w_dom_nxt   = '0;
      end else begin
        w_state_nxt = ST_RELEASE;
        w_dom_nxt   = DW'(1);
      end
    end

    if (w_loss || w_abort) begin
      w_state_nxt = ST_HOLD;
      w_filt_nxt  = '0;
      w_step_nxt  = '0;
      w_dom_nxt   = '0;
      w_rst_nxt   = '0;
      w_ready_nxt = 1'b0;
      if (w_loss && (r_loss_cnt != '1)) begin
        w_loss_nxt = r_loss_cnt + LOSS_W'(1);
      end
    end
  end

  assign RST_OUTn = r_rst_out;
  assign READY    = r_ready;
  assign LOSS_CNT = r_loss_cnt;
  assign STATE    = r_state;

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
Parametrised reset sequencer for FPGA top wrappers. It replaces the ad-hoc AND of the board reset with the PLL lock signals. It synchronises N_LOCK PLL lock inputs and an external reset button, filters lock glitches, and releases N_DOM reset domains in a fixed order with programmable spacing. Any lock loss or external reset re-asserts all domains. It also exposes a ready flag, a loss counter and the FSM state for debug.

Parameters:
N_LOCK, 2, number of PLL LOCKED inputs; must be >= 1
N_DOM, 3, number of sequenced reset domains; must be >= 1
SYNC_STAGES, 2, synchroniser depth for LOCKED/EXT_RSTn; must be >= 2
LOCK_FILT, 16, consecutive good cycles required before release; must be >= 1
STEP_DLY, 64, cycles between successive domain releases; must be >= 1
LOSS_W, 8, width of the lock-loss event counter

Ports:
CLK  input  1  sequencer clock; free-running, not PLL-derived
RESETn  input  1  asynchronous active-low reset of this block
LOCKED  input  N_LOCK  PLL lock flags; asynchronous to CLK
EXT_RSTn  input  1  board reset button, active-low; asynchronous to CLK
SW_REQ  input  1  synchronous single-cycle request to re-run the sequence
RST_OUTn  output  N_DOM  per-domain active-low resets; bit 0 is released first
READY  output  1  high when all domains are released
LOSS_CNT  output  LOSS_W  count of good-to-bad events after the sequence has started
STATE  output  2  FSM state: 0 HOLD, 1 FILTER, 2 RELEASE, 3 RUN

Behaviour:
- Reset (RESETn low, asynchronous): RST_OUTn = 0, READY = 0, LOSS_CNT = 0, STATE = HOLD, all synchroniser flops = 0, counters = 0.
- Synchronisers: each LOCKED bit and EXT_RSTn passes through SYNC_STAGES flops. Define all_ok = (&locked_s) & ext_s.
- All outputs are registered. There is no combinational path from any input to any output.
- HOLD:
  - RST_OUTn = 0.
  - Go to FILTER when all_ok = 1; the filter counter is loaded with 1.
- FILTER:
  - While all_ok = 1, the counter increments.
  - When the counter reaches LOCK_FILT with all_ok = 1, go to RELEASE and set RST_OUTn[0] = 1 on that same edge. The step counter is cleared.
  - all_ok = 0 returns to HOLD and clears the counter. This is not counted as a loss.
- RELEASE:
  - The step counter runs. Every STEP_DLY cycles, the next RST_OUTn bit goes high, in index order.
  - When bit N_DOM-1 is set, go to RUN and set READY = 1 on the same edge.
  - If N_DOM = 1, go directly from FILTER to RUN.
- RUN: hold all outputs released.
- Latency, in edges from the first edge that samples all inputs good at the synchroniser input:
  - RST_OUTn[0] rises at L0 = SYNC_STAGES + LOCK_FILT.
  - RST_OUTn[k] rises at L0 + k*STEP_DLY.
  - Defaults: 18, 82, 146.
- Loss of good inputs:
  - Condition: all_ok = 0 while in RELEASE or RUN.
  - Next edge: RST_OUTn = 0 on all bits simultaneously, READY = 0, STATE = HOLD, counters cleared.
  - LOSS_CNT increments by 1 and saturates at 2^LOSS_W-1.
  - Pin-to-assert latency is at most SYNC_STAGES+1 edges.
- SW_REQ:
  - In FILTER, RELEASE or RUN: same effect as a loss, except LOSS_CNT is not incremented.
  - In HOLD: ignored.
  - If SW_REQ and all_ok = 0 occur in the same cycle, this is a loss: LOSS_CNT increments once.
- Glitches:
  - A LOCKED or EXT_RSTn low pulse shorter than one CLK period may be missed.
  - A pulse of at least 2 CLK periods is always seen.
- Re-entry from HOLD always restarts the full filter and sequence. There is no partial resume.
- Counter widths: ceil(log2(LOCK_FILT+1)) for the filter counter and ceil(log2(STEP_DLY+1)) for the step counter; neither counter wraps.
- Domain index counter width: ceil(log2(N_DOM)), minimum 1.

Test Plan:
- Power-up, defaults: RESETn released, LOCKED=2'b11, EXT_RSTn=1 from cycle 0 -> RST_OUTn bits 0/1/2 rise at edges 18/82/146; READY rises at 146; LOSS_CNT=0; STATE goes 0->1->2->3.
- Filter glitch: LOCKED[1] drops for 3 cycles at filter count 10 -> STATE returns to HOLD, LOSS_CNT stays 0, and the full 16-cycle filter restarts after recovery.
- Loss in RUN: LOCKED[0] low for 4 cycles -> all RST_OUTn = 0 within 3 edges, READY = 0, LOSS_CNT = 1; after recovery the sequence repeats with the same 18/82/146 spacing.
- Mid-sequence loss plus SW_REQ: EXT_RSTn low and SW_REQ pulse in the same cycle during RELEASE with RST_OUTn = 3'b001 -> RST_OUTn = 0, LOSS_CNT +1 (not +2); a later SW_REQ alone in RUN -> re-sequence, LOSS_CNT unchanged.
- Saturation (LOSS_W=2): 5 loss events -> LOSS_CNT reads 1,2,3,3,3.
- Async reset mid-RELEASE: RESETn low with RST_OUTn = 3'b011 -> outputs 0 with no clock edge; after release the sequence restarts from HOLD. Repeat with N_DOM=1, STEP_DLY=1 -> RST_OUTn[0] and READY rise together at edge 18.
